// File: rtl/mem_access_ctrl_if.sv
// Data-bus bundle between the MEM-stage access controller and the memory
// system. The controller (master) drives the request side; the memory
// (slave) returns read data and the completion acknowledge.
interface mem_access_ctrl_if;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBE;
    logic [31:0] BusWData;
    logic [31:0] BusRData;
    logic        BusAck;

    modport master (
        output BusReq, BusWe, BusAddr, BusBE, BusWData,
        input  BusRData, BusAck
    );

    modport slave (
        input  BusReq, BusWe, BusAddr, BusBE, BusWData,
        output BusRData, BusAck
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller.
// Accepts load/store commands, rejects misaligned or contradictory ones,
// runs one req/ack transfer on the data bus, stalls the pipeline while the
// transfer is outstanding and hands the raw read word, Addr[1:0] and
// LoadType to the downstream byte-extract/sign-extend unit.
// Optional feature macro: MEM_TIMEOUT_EN (abandon a transfer after TIMEOUT
// cycles without acknowledge and flag BusErr).
module mem_access_ctrl #(
    parameter int TIMEOUT  = 16,
    parameter int TO_CNT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [2:0]          LoadType,
    input  logic [1:0]          StoreType,
    input  logic [31:0]         Addr,
    input  logic [31:0]         WriteData,
    mem_access_ctrl_if.master   bus,
    output logic                MemStall,
    output logic                MemValid,
    output logic [31:0]         MemData_o,
    output logic [1:0]          ALUOut_o,
    output logic [2:0]          LoadType_o,
    output logic                AddrErr,
    output logic [31:0]         BadAddr,
    output logic                BusErr
);
    // LoadType codes shared with the extract unit; any other code is a word load.
    localparam logic [2:0] LD_HALF  = 3'd1;
    localparam logic [2:0] LD_HALFU = 3'd2;
    localparam logic [2:0] LD_BYTE  = 3'd3;
    localparam logic [2:0] LD_BYTEU = 3'd4;
    // StoreType 2'b11 is reserved and handled as a word store.
    localparam logic [1:0] ST_HALF  = 2'b01;
    localparam logic [1:0] ST_BYTE  = 2'b10;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_reg;
    logic        bus_req_reg;
    logic        bus_we_reg;
    logic [31:0] bus_addr_reg;
    logic [3:0]  bus_be_reg;
    logic [31:0] bus_wdata_reg;
    logic        mem_valid_reg;
    logic [31:0] mem_data_reg;
    logic [1:0]  alu_out_reg;
    logic [2:0]  load_type_reg;
    logic        addr_err_reg;
    logic [31:0] bad_addr_reg;

    logic        acc_half;
    logic        acc_byte;
    logic        misaligned;
    logic        illegal;
    logic        req_ok;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;

    // Access size comes from LoadType for loads and StoreType for stores.
    assign acc_half   = MemRead ? ((LoadType == LD_HALF) || (LoadType == LD_HALFU))
                                : (StoreType == ST_HALF);
    assign acc_byte   = MemRead ? ((LoadType == LD_BYTE) || (LoadType == LD_BYTEU))
                                : (StoreType == ST_BYTE);
    assign misaligned = acc_byte ? 1'b0 : (acc_half ? Addr[0] : (Addr[1:0] != 2'b00));
    assign illegal    = MemRead & MemWrite;
    assign req_ok     = (MemRead | MemWrite) & ~illegal & ~misaligned;

    // Stall the request cycle only for requests that will actually reach the bus.
    assign MemStall = (state_reg == REQ) || ((state_reg == IDLE) && req_ok);

    // Per-lane byte enable and replicated store data.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign be_next[gi] = MemRead | ~(acc_half | acc_byte)
                               | (acc_half & (Addr[1] == LANE[1]))
                               | (acc_byte & (Addr[1:0] == LANE));
            assign wdata_next[8*gi +: 8] = acc_byte ? WriteData[7:0]
                                         : acc_half ? WriteData[8*(gi%2) +: 8]
                                         : WriteData[8*gi +: 8];
        end
    endgenerate

    // A zero-width counter or a zero limit cannot describe a usable timeout.
    if (TO_CNT_W < 1 || TIMEOUT < 1) begin : g_timeout_cfg_invalid
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);
    logic [TO_CNT_W-1:0] to_cnt_reg;
    logic                bus_err_reg;
    assign BusErr = bus_err_reg;
`else
    assign BusErr = 1'b0;
`endif

    // Access FSM: IDLE accepts/rejects, REQ holds the bus until ack, DONE reports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'h0;
            bus_be_reg    <= 4'h0;
            bus_wdata_reg <= 32'h0;
            mem_valid_reg <= 1'b0;
            mem_data_reg  <= 32'h0;
            alu_out_reg   <= 2'b00;
            load_type_reg <= 3'd0;
            addr_err_reg  <= 1'b0;
            bad_addr_reg  <= 32'h0;
`ifdef MEM_TIMEOUT_EN
            to_cnt_reg    <= '0;
            bus_err_reg   <= 1'b0;
`endif
        end else begin
            mem_valid_reg <= 1'b0;
            addr_err_reg  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_err_reg   <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (req_ok) begin
                        bus_req_reg   <= 1'b1;
                        bus_we_reg    <= MemWrite;
                        bus_addr_reg  <= {Addr[31:2], 2'b00};
                        bus_be_reg    <= be_next;
                        bus_wdata_reg <= wdata_next;
                        // Extract-unit sideband only tracks loads so it stays
                        // consistent with the read word it accompanies.
                        if (MemRead) begin
                            alu_out_reg   <= Addr[1:0];
                            load_type_reg <= LoadType;
                        end
`ifdef MEM_TIMEOUT_EN
                        to_cnt_reg    <= '0;
`endif
                        state_reg     <= REQ;
                    end else if (MemRead | MemWrite) begin
                        addr_err_reg <= 1'b1;
                        bad_addr_reg <= Addr;
                    end
                end
                REQ: begin
                    if (bus.BusAck) begin
                        bus_req_reg   <= 1'b0;
                        if (!bus_we_reg)
                            mem_data_reg <= bus.BusRData;
                        mem_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (to_cnt_reg == TO_LAST) begin
                        bus_req_reg   <= 1'b0;
                        bus_err_reg   <= 1'b1;
                        mem_data_reg  <= 32'h0;
                        mem_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.BusReq   = bus_req_reg;
    assign bus.BusWe    = bus_we_reg;
    assign bus.BusAddr  = bus_addr_reg;
    assign bus.BusBE    = bus_be_reg;
    assign bus.BusWData = bus_wdata_reg;
    assign MemValid     = mem_valid_reg;
    assign MemData_o    = mem_data_reg;
    assign ALUOut_o     = alu_out_reg;
    assign LoadType_o   = load_type_reg;
    assign AddrErr      = addr_err_reg;
    assign BadAddr      = bad_addr_reg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a table of load/store vectors with an
// inline bus responder, a scoreboard of expected completions, and
// hand-written reset and timeout sequences.
module tb_mem_access_ctrl;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4;
    localparam logic [1:0] SW = 2'b00, SH = 2'b01, SB = 2'b10, SR = 2'b11;
`ifdef MEM_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
    localparam int LONG_DLY   = 3;  // ack lands exactly on the timeout limit
`else
    localparam int TB_TIMEOUT = 16;
    localparam int LONG_DLY   = 4;  // ack in the fifth REQ cycle
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemRead, MemWrite;
    logic [2:0]  LoadType;
    logic [1:0]  StoreType;
    logic [31:0] Addr, WriteData;
    logic        MemStall, MemValid, AddrErr, BusErr;
    logic [31:0] MemData_o, BadAddr;
    logic [1:0]  ALUOut_o;
    logic [2:0]  LoadType_o;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TB_TIMEOUT), .TO_CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .LoadType(LoadType), .StoreType(StoreType),
        .Addr(Addr), .WriteData(WriteData), .bus(bus.master),
        .MemStall(MemStall), .MemValid(MemValid), .MemData_o(MemData_o), .ALUOut_o(ALUOut_o),
        .LoadType_o(LoadType_o), .AddrErr(AddrErr), .BadAddr(BadAddr), .BusErr(BusErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  ltype;
        logic [1:0]  stype;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        logic        err;
        logic [3:0]  be;
        logic [31:0] bwdata;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  alu;
        logic [2:0]  lt;
        logic        is_rd;
    } exp_t;

    exp_t sb_q[$];
    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] m_data;
    logic [1:0]  m_alu;
    logic [2:0]  m_lt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        MemRead = 1'b0; MemWrite = 1'b0; LoadType = LW; StoreType = SW;
        Addr = 32'h0; WriteData = 32'h0;
    endtask

    // Legal request that must be ignored while the controller is busy.
    task automatic junk_inputs();
        MemRead = 1'b1; MemWrite = 1'b0; LoadType = LW; StoreType = SW;
        Addr = 32'hFFFF_FFF0; WriteData = 32'h1357_9BDF;
    endtask

    // Scoreboard: every completion pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && MemValid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_memvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_memdata", MemData_o, e.data);
                if (e.is_rd) begin
                    chk("sb_aluout", {30'h0, ALUOut_o}, {30'h0, e.alu});
                    chk("sb_loadtype", {29'h0, LoadType_o}, {29'h0, e.lt});
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        MemRead = v.rd; MemWrite = v.wr; LoadType = v.ltype; StoreType = v.stype;
        Addr = v.addr; WriteData = v.wdata;
        bus.BusAck = 1'b0;
        if (!v.err) begin
            if (v.rd) begin
                m_data = v.rdata; m_alu = v.addr[1:0]; m_lt = v.ltype;
            end
            e.data = m_data; e.alu = m_alu; e.lt = m_lt; e.is_rd = v.rd;
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (MemStall) stall_cnt++;
        chk("req_stall", {31'h0, MemStall}, {31'h0, ~v.err});
        @(posedge clk); #1;
        if (v.err) begin
            idle_inputs();
            chk("addr_err", {31'h0, AddrErr}, 32'd1);
            chk("bad_addr", BadAddr, v.addr);
            chk("err_no_busreq", {31'h0, bus.BusReq}, 32'd0);
            chk("err_no_stall", {31'h0, MemStall}, 32'd0);
            @(posedge clk); #1;
            chk("addr_err_pulse", {31'h0, AddrErr}, 32'd0);
            chk("err_still_no_busreq", {31'h0, bus.BusReq}, 32'd0);
        end else begin
            chk("bus_req", {31'h0, bus.BusReq}, 32'd1);
            chk("bus_we", {31'h0, bus.BusWe}, {31'h0, v.wr});
            chk("bus_be", {28'h0, bus.BusBE}, {28'h0, v.be});
            if (v.wr) chk("bus_wdata", bus.BusWData, v.bwdata);
            junk_inputs();
            for (int w = 0; w <= v.dly; w++) begin
                bus.BusAck   = (w == v.dly);
                bus.BusRData = (w == v.dly) ? v.rdata : (32'hBAD0_0000 | w);
                @(negedge clk);
                if (MemStall) stall_cnt++;
                chk("bus_addr_hold", bus.BusAddr, {v.addr[31:2], 2'b00});
                @(posedge clk); #1;
            end
            bus.BusAck = 1'b0;
            chk("done_busreq", {31'h0, bus.BusReq}, 32'd0);
            chk("done_memvalid", {31'h0, MemValid}, 32'd1);
            chk("done_buserr", {31'h0, BusErr}, 32'd0);
            @(negedge clk);
            if (MemStall) stall_cnt++;
            @(posedge clk); #1;
            idle_inputs();
            chk("no_accept_in_done", {31'h0, bus.BusReq}, 32'd0);
            chk("memvalid_pulse", {31'h0, MemValid}, 32'd0);
            chk("stall_cycles", stall_cnt, v.dly + 2);
        end
        $display("vec %0d: rd=%0b wr=%0b addr=%h err=%0b stall=%0d", idx, v.rd, v.wr, v.addr, v.err, stall_cnt);
    endtask

    vec_t vecs[14];

    initial begin
        //        rd wr ltype stype addr           wdata          rdata          dly       err be    bwdata
        vecs[0]  = '{1'b1, 1'b0, LW,  SW, 32'h0000_0100, 32'h0,         32'h8899_AABB, 0,        1'b0, 4'hF, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, LW,  SB, 32'h0000_0203, 32'h0000_005A, 32'h0,         0,        1'b0, 4'h8, 32'h5A5A_5A5A};
        vecs[2]  = '{1'b1, 1'b0, LH,  SW, 32'h0000_0102, 32'h0,         32'h1122_3344, 1,        1'b0, 4'hF, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, LW,  SH, 32'h0000_0105, 32'h0000_BEEF, 32'h0,         0,        1'b1, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, LW,  SH, 32'h0000_0106, 32'hABCD_1234, 32'h0,         2,        1'b0, 4'hC, 32'h1234_1234};
        vecs[5]  = '{1'b0, 1'b1, LW,  SR, 32'h0000_0030, 32'hDEAD_BEEF, 32'h0,         1,        1'b0, 4'hF, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b1, 1'b0, LB,  SW, 32'h0000_0401, 32'h0,         32'hCAFE_F00D, 0,        1'b0, 4'hF, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, LW,  SW, 32'h0000_0402, 32'h0,         32'h0,         0,        1'b1, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, LW,  SW, 32'h0000_0500, 32'h0,         32'h0,         0,        1'b1, 4'h0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, LHU, SW, 32'h0000_0103, 32'h0,         32'h0,         0,        1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, LW,  SB, 32'h0000_0000, 32'h1234_56A7, 32'h0,         0,        1'b0, 4'h1, 32'hA7A7_A7A7};
        vecs[11] = '{1'b1, 1'b0, LBU, SW, 32'h0000_0007, 32'h0,         32'h55AA_0001, 3,        1'b0, 4'hF, 32'h0};
        vecs[12] = '{1'b1, 1'b0, LW,  SW, 32'h0000_0600, 32'h0,         32'h0F1E_2D3C, LONG_DLY, 1'b0, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 1'b1, LW,  SB, 32'h0000_0222, 32'h0000_00C3, 32'h0,         1,        1'b0, 4'h4, 32'hC3C3_C3C3};

        m_data = 32'h0; m_alu = 2'b00; m_lt = 3'd0;
        idle_inputs();
        bus.BusAck = 1'b0; bus.BusRData = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busreq", {31'h0, bus.BusReq}, 32'd0);
        chk("rst_memvalid", {31'h0, MemValid}, 32'd0);
        chk("rst_memdata", MemData_o, 32'h0);
        chk("rst_badaddr", BadAddr, 32'h0);
        chk("rst_addrerr", {31'h0, AddrErr}, 32'd0);
        chk("rst_stall", {31'h0, MemStall}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Reset while in REQ with an acknowledge present: the ack must be lost.
        MemRead = 1'b1; LoadType = LH; Addr = 32'h0000_0702;
        @(posedge clk); #1;
        chk("rstreq_busreq_before", {31'h0, bus.BusReq}, 32'd1);
        idle_inputs();
        bus.BusAck = 1'b1; bus.BusRData = 32'hFFFF_0000;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus.BusAck = 1'b0;
        m_data = 32'h0; m_alu = 2'b00; m_lt = 3'd0;
        chk("rstreq_busreq", {31'h0, bus.BusReq}, 32'd0);
        chk("rstreq_memvalid", {31'h0, MemValid}, 32'd0);
        chk("rstreq_memdata", MemData_o, 32'h0);
        chk("rstreq_aluout", {30'h0, ALUOut_o}, 32'd0);
        chk("rstreq_badaddr", BadAddr, 32'h0);
        @(posedge clk); #1;
        chk("rstreq_no_late_valid", {31'h0, MemValid}, 32'd0);
        $display("reset-in-REQ sequence done");

`ifdef MEM_TIMEOUT_EN
        // No acknowledge at all: the transfer is abandoned after TIMEOUT REQ cycles.
        begin
            exp_t e;
            MemRead = 1'b1; LoadType = LW; Addr = 32'h0000_0800;
            m_data = 32'h0; m_alu = 2'b00; m_lt = LW;
            e.data = 32'h0; e.alu = 2'b00; e.lt = LW; e.is_rd = 1'b1;
            sb_q.push_back(e);
            @(posedge clk); #1;
            idle_inputs();
            for (int c = 0; c < TB_TIMEOUT; c++) begin
                @(negedge clk);
                chk("to_busreq_held", {31'h0, bus.BusReq}, 32'd1);
                chk("to_no_buserr_yet", {31'h0, BusErr}, 32'd0);
                @(posedge clk); #1;
            end
            chk("to_busreq_drop", {31'h0, bus.BusReq}, 32'd0);
            chk("to_buserr", {31'h0, BusErr}, 32'd1);
            chk("to_memvalid", {31'h0, MemValid}, 32'd1);
            chk("to_memdata", MemData_o, 32'h0);
            @(posedge clk); #1;
            chk("to_buserr_pulse", {31'h0, BusErr}, 32'd0);
            $display("timeout sequence done");
        end
`else
        chk("buserr_tied_low", {31'h0, BusErr}, 32'd0);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
